contador_bits_param: RTL and testbench
======================================

// Module: contador_bits_param
// PURPOSE
//   Parametrised bit counter with integrated control FSM: counts the 1s (or 0s) in a
//   WIDTH-bit word by shift-right scanning, ending early once no target bits remain.
//   Datapath and controller in one block, with a start/busy/done handshake.
//   Used wherever the system needs a population count without a separate controller.
// PARAMETERS
//   WIDTH  16                   data word width, >= 2
//   CNT_W  $clog2(WIDTH+1)      result width, holds 0..WIDTH inclusive
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset     in   1      asynchronous, active-low reset (0 = reset)
//   start     in   1      request a count; sampled only in IDLE
//   mode      in   1      0 = count 1s, 1 = count 0s; sampled with start
//   data_in   in   WIDTH  word to count; sampled with start
//   busy      out  1      high in SCAN and DONE
//   done      out  1      one-cycle pulse, result valid from this cycle
//   result    out  CNT_W  last completed count; held until next done
//   zero_word out  1      last completed word had no target bits (result==0)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, shift reg=0, acc=0, result=0, zero_word=0,
//     busy=0, done=0. Release is synchronous to clk.
//   IDLE: busy=0, done=0. On edge with start=1: shreg <= mode ? ~data_in : data_in;
//     acc <= 0; -> SCAN. start=0: stay.
//   SCAN: per edge: if shreg==0 -> result<=acc, zero_word<=(acc==0), -> DONE;
//     else acc <= acc + shreg[0], shreg <= {1'b0, shreg[WIDTH-1:1]}.
//   DONE: done=1, busy=1 for exactly one cycle; next edge -> IDLE.
//   Latency: k = (index of MSB set in loaded shreg)+1, k=0 if shreg==0.
//     done is high k+2 cycles after the start-sampling edge; max WIDTH+2.
//   result/zero_word change only on the SCAN->DONE edge; partial counts never visible.
//   start in SCAN or DONE: ignored, no queuing; mode/data_in changes while busy: ignored.
//   start held high: a new count begins on the edge after DONE (IDLE sees start).
//   Width: acc and result are CNT_W bits; WIDTH all-ones gives result=WIDTH, no overflow.
//   Reset mid-SCAN: aborts immediately, all values as reset; no done pulse.
//   busy and done are registered-state decodes, glitch-free, no combinational path
//     from start/data_in to any output.
// TESTING
//   1 WIDTH=16, mode=0, data_in=16'h0000 -> done 2 cycles after start, result=0, zero_word=1.
//   2 mode=0, data_in=16'hFFFF -> done after 18 cycles, result=16, zero_word=0.
//   3 mode=0, data_in=16'h00A5 -> done after 10 cycles (early end), result=4;
//     same word mode=1 -> ~=16'hFF5A, done after 18 cycles, result=12.
//   4 start pulsed during SCAN with new data -> ignored; result is the first word's
//     count; start held high -> back-to-back counts, one done per word.
//   5 reset=0 during SCAN of 16'hF0F0 -> busy=0, result=0, no done; next count correct.
//   6 WIDTH=8 (CNT_W=4), data_in=8'hFF, mode=0 -> result=8, done after 10 cycles.

Source files
------------

// File: rtl/contador_bits_param_if.sv
// Handshake and data bundle between a requester and the bit counter.
interface contador_bits_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] result;
  logic             zero_word;

  // Requester side: issues counts and observes status/result.
  modport master (
    output start, mode, data_in,
    input  busy, done, result, zero_word
  );

  // Counter side.
  modport slave (
    input  start, mode, data_in,
    output busy, done, result, zero_word
  );
endinterface

// File: rtl/contador_bits_param.sv
// Population counter: scans a WIDTH-bit word LSB-first, ending as soon as no
// target bits remain. Counts 1s (mode=0) or 0s (mode=1).
module contador_bits_param #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic                  clk,
  input logic                  reset,
  contador_bits_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, done_q;

  // Next-state, datapath and result update.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d = bus.mode ? ~bus.data_in : bus.data_in;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (shreg_q == '0) begin
          // Result publishes only here, so partial counts never appear.
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          state_d  = DONE;
        end else begin
          acc_d   = acc_q + CNT_W'(shreg_q[0]);
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.zero_word = zero_q;

endmodule

// File: tb/tb_contador_bits_param.sv
// Directed bench for contador_bits_param at WIDTH=16 and WIDTH=8.
module tb_contador_bits_param;

  localparam int unsigned W16 = 16;
  localparam int unsigned C16 = 5;
  localparam int unsigned W8  = 8;
  localparam int unsigned C8  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  contador_bits_param_if #(.WIDTH(W16), .CNT_W(C16)) bus16 ();
  contador_bits_param_if #(.WIDTH(W8),  .CNT_W(C8))  bus8 ();

  contador_bits_param #(.WIDTH(W16), .CNT_W(C16)) dut16 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus16)
  );

  contador_bits_param #(.WIDTH(W8), .CNT_W(C8)) dut8 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        mode;
    int          exp_result;
    int          exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One full count on the 16-bit instance; latency counts the sampling edge as cycle 1.
  task automatic run16(input logic [15:0] d, input logic m, input int er,
                       input int ez, input int el, input string nm);
    int         n;
    logic       seen;
    logic       held;
    logic [4:0] r0;
    @(negedge clk);
    bus16.start   = 1'b1;
    bus16.data_in = d;
    bus16.mode    = m;
    r0 = bus16.result;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 1; seen = 1'b0; held = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus16.done) seen = 1'b1;
      else if (bus16.result !== r0) held = 1'b0;
    end
    chk({nm, "_latency"}, seen ? n : -1, el);
    chk({nm, "_result"}, int'(bus16.result), er);
    chk({nm, "_zero"}, int'(bus16.zero_word), ez);
    chk({nm, "_busy_at_done"}, int'(bus16.busy), 1);
    chk({nm, "_result_held"}, int'(held), 1);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(bus16.done), 0);
    chk({nm, "_idle_busy"}, int'(bus16.busy), 0);
  endtask

  task automatic run8(input logic [7:0] d, input logic m, input int er,
                      input int ez, input int el, input string nm);
    int   n;
    logic seen;
    @(negedge clk);
    bus8.start   = 1'b1;
    bus8.data_in = d;
    bus8.mode    = m;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (bus8.done) seen = 1'b1;
    end
    chk({nm, "_latency"}, seen ? n : -1, el);
    chk({nm, "_result"}, int'(bus8.result), er);
    chk({nm, "_zero"}, int'(bus8.zero_word), ez);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, int'(bus8.done), 0);
  endtask

  initial begin
    vec_t vecs[9];
    int   n;
    int   pulses;
    int   prev_done;
    logic seen;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.mode = 1'b0; bus16.data_in = '0;
    bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.data_in  = '0;

    vecs[0] = '{16'h0000, 1'b0, 0,  1, 2};
    vecs[1] = '{16'hFFFF, 1'b0, 16, 0, 18};
    vecs[2] = '{16'h00A5, 1'b0, 4,  0, 10};
    vecs[3] = '{16'h00A5, 1'b1, 12, 0, 18};
    vecs[4] = '{16'h0001, 1'b0, 1,  0, 3};
    vecs[5] = '{16'h8000, 1'b0, 1,  0, 18};
    vecs[6] = '{16'hFFFF, 1'b1, 0,  1, 2};
    vecs[7] = '{16'h0000, 1'b1, 16, 0, 18};
    vecs[8] = '{16'h0F00, 1'b0, 4,  0, 14};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus16.busy), 0);
    chk("rst_done", int'(bus16.done), 0);
    chk("rst_result", int'(bus16.result), 0);
    chk("rst_zero", int'(bus16.zero_word), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", int'(bus16.busy), 0);

    for (int i = 0; i < 9; i++) begin
      run16(vecs[i].data, vecs[i].mode, vecs[i].exp_result,
            vecs[i].exp_zero, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // start with new data during SCAN must be ignored.
    @(negedge clk);
    bus16.start = 1'b1; bus16.data_in = 16'h00A5; bus16.mode = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) begin
        bus16.start = 1'b1; bus16.data_in = 16'hFFFF; bus16.mode = 1'b1;
      end else begin
        bus16.start = 1'b0;
      end
      if (bus16.done) seen = 1'b1;
    end
    chk("ign_latency", seen ? n : -1, 10);
    chk("ign_result", int'(bus16.result), 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign_no_requeue", int'(bus16.busy), 0);

    // start held high: counts run back to back, one done per word.
    @(negedge clk);
    bus16.start = 1'b1; bus16.data_in = 16'h0003; bus16.mode = 1'b0;
    pulses = 0; prev_done = 0;
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      if (bus16.done) begin
        pulses++;
        chk("held_result", int'(bus16.result), 2);
        chk("held_single_cycle", prev_done, 0);
      end
      prev_done = int'(bus16.done);
    end
    chk("held_pulses", pulses, 4);
    bus16.start = 1'b0;
    n = 0;
    while (bus16.busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_drain", int'(bus16.busy), 0);

    // Reset mid-SCAN aborts without a done pulse.
    @(negedge clk);
    bus16.start = 1'b1; bus16.data_in = 16'hF0F0; bus16.mode = 1'b0;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus16.busy), 0);
    chk("abort_result", int'(bus16.result), 0);
    chk("abort_zero", int'(bus16.zero_word), 0);
    chk("abort_done", int'(bus16.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus16.done || bus16.busy) pulses++;
    end
    chk("abort_quiet", pulses, 0);
    run16(16'h0007, 1'b0, 3, 0, 5, "after_abort");

    // Narrow instance.
    run8(8'hFF, 1'b0, 8, 0, 10, "w8_ff");
    run8(8'h00, 1'b0, 0, 1, 2,  "w8_00");
    run8(8'h80, 1'b0, 1, 0, 10, "w8_80");
    run8(8'hF0, 1'b1, 4, 0, 6,  "w8_f0_zeros");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
